ysyx_22041412_gpr_sched: RTL and testbench

Write-port scheduler and hazard scoreboard for the 32×64-bit general-purpose register file. Arbitrates two writeback sources (EXU single-cycle, LSU multi-cycle) onto the register file's single write port (Wen/Rw/BusW), and tracks per-register pending writes so the decoder stalls on RAW/WAW hazards. Sits between IDU/EXU/LSU and the register file; its write-port outputs drive the register file directly.

---
 rtl/ysyx_22041412_gpr_sched.sv | 106 ++++++++++
 tb/tb_ysyx_22041412_gpr_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_gpr_sched.sv
// GPR write-port scheduler: round-robin EXU/LSU arbitration onto the single
// register-file write port, plus a per-register pending-write scoreboard.
module ysyx_22041412_gpr_sb_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic busy
);
  // set has priority so a new issue survives the commit of the older write
  always_ff @(posedge clk) begin
    if (!rst)     busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module ysyx_22041412_gpr_sched #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_en,
  output logic            issue_ready,
  input  logic            exu_valid,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rw,
  output logic [XLEN-1:0] gpr_busw,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  wb_req_t         exu_req, lsu_req, win;
  logic            ptr;          // 0: EXU wins a contest, 1: LSU wins
  logic            contested, gnt, issue_fire;
  logic [NREG-1:0] sb, sb_set, sb_clr;

  assign exu_req = '{rd: exu_rd, data: exu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};

  assign contested = exu_valid & lsu_valid;
  assign exu_ready = rst & exu_valid & (~lsu_valid | ~ptr);
  assign lsu_ready = rst & lsu_valid & (~exu_valid | ptr);
  assign gnt       = exu_ready | lsu_ready;
  assign win       = lsu_ready ? lsu_req : exu_req;

  // hazard check looks only at registered scoreboard state
  assign issue_ready = rst & ~sb[issue_rs1] & ~sb[issue_rs2]
                     & ~(issue_rd_en & sb[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready;

  assign sb[0]     = 1'b0;
  assign sb_set[0] = 1'b0;
  assign sb_clr[0] = 1'b0;
  assign busy      = sb;

  genvar i;
  generate
    for (i = 1; i < NREG; i++) begin : g_sb
      assign sb_set[i] = issue_fire & issue_rd_en & (issue_rd == 5'(i));
      assign sb_clr[i] = gpr_wen & (gpr_rw == 5'(i));
      ysyx_22041412_gpr_sb_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .set  (sb_set[i]),
        .clr  (sb_clr[i]),
        .busy (sb[i])
      );
    end
  endgenerate

  // rd=0 grants consume the port slot but never assert gpr_wen
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= 1'b0;
      gpr_wen  <= 1'b0;
      gpr_rw   <= '0;
      gpr_busw <= '0;
      wb_err   <= 1'b0;
    end else begin
      if (contested) ptr <= ~ptr;
      gpr_wen <= gnt & (win.rd != 5'd0);
      if (gnt) begin
        gpr_rw   <= win.rd;
        gpr_busw <= win.data;
        if ((win.rd != 5'd0) && !sb[win.rd]) wb_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041412_gpr_sched.sv
// Directed table-driven bench for the GPR write-port scheduler/scoreboard.
module tb_ysyx_22041412_gpr_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_rd_en, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, gpr_rw;
  logic [63:0] exu_data, lsu_data, gpr_busw;
  logic        gpr_wen, wb_err;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22041412_gpr_sched #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_ready(issue_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .gpr_wen(gpr_wen), .gpr_rw(gpr_rw), .gpr_busw(gpr_busw),
    .busy(busy), .wb_err(wb_err)
  );

  typedef struct {
    logic        r, iv;
    logic [4:0]  s1, s2, d;
    logic        den, ev;
    logic [4:0]  erd;
    logic [63:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        xir, xer, xlr, xwen;
    logic [4:0]  xrw;
    logic [63:0] xbusw;
    logic [31:0] xbusy;
    logic        xerr;
  } vec_t;

  function automatic vec_t v(
    input logic r, iv, input logic [4:0] s1, s2, d, input logic den,
    input logic ev, input logic [4:0] erd, input logic [63:0] ed,
    input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
    input logic xir, xer, xlr, xwen, input logic [4:0] xrw,
    input logic [63:0] xbusw, input logic [31:0] xbusy, input logic xerr);
    vec_t t;
    t.r = r; t.iv = iv; t.s1 = s1; t.s2 = s2; t.d = d; t.den = den;
    t.ev = ev; t.erd = erd; t.ed = ed; t.lv = lv; t.lrd = lrd; t.ld = ld;
    t.xir = xir; t.xer = xer; t.xlr = xlr; t.xwen = xwen; t.xrw = xrw;
    t.xbusw = xbusw; t.xbusy = xbusy; t.xerr = xerr;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.r; issue_valid = t.iv; issue_rs1 = t.s1; issue_rs2 = t.s2;
    issue_rd = t.d; issue_rd_en = t.den;
    exu_valid = t.ev; exu_rd = t.erd; exu_data = t.ed;
    lsu_valid = t.lv; lsu_rd = t.lrd; lsu_data = t.ld;
  endtask

  // comb outputs checked before the edge, registered outputs just after it
  task automatic apply(input vec_t t, input int idx);
    drive(t);
    #1;
    chk("issue_ready", idx, 64'(issue_ready), 64'(t.xir));
    chk("exu_ready",   idx, 64'(exu_ready),   64'(t.xer));
    chk("lsu_ready",   idx, 64'(lsu_ready),   64'(t.xlr));
    @(posedge clk); #1;
    chk("gpr_wen",  idx, 64'(gpr_wen), 64'(t.xwen));
    chk("gpr_rw",   idx, 64'(gpr_rw),  64'(t.xrw));
    chk("gpr_busw", idx, gpr_busw,     t.xbusw);
    chk("busy",     idx, 64'(busy),    64'(t.xbusy));
    chk("wb_err",   idx, 64'(wb_err),  64'(t.xerr));
  endtask

  vec_t tbl[$];

  initial begin
    drive(v(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0,0));
    //       r iv s1 s2 d den  ev erd ed          lv lrd ld      ir er lr wen rw busw       busy    err
    // reset with everything requesting, then release
    tbl.push_back(v(0,1,5,5,5,1, 1,1,64'h1,       1,2,64'h2,     0,0,0, 0,0,64'h0,       32'h0,  0));
    tbl.push_back(v(0,1,5,5,5,1, 1,1,64'h1,       1,2,64'h2,     0,0,0, 0,0,64'h0,       32'h0,  0));
    tbl.push_back(v(1,0,5,5,5,1, 0,0,0,           0,0,0,         1,0,0, 0,0,64'h0,       32'h0,  0));
    // RAW stall on x5 until EXU commit
    tbl.push_back(v(1,1,0,0,5,1, 0,0,0,           0,0,0,         1,0,0, 0,0,64'h0,       32'h20, 0));
    tbl.push_back(v(1,1,5,0,0,0, 0,0,0,           0,0,0,         0,0,0, 0,0,64'h0,       32'h20, 0));
    tbl.push_back(v(1,1,5,0,0,0, 0,0,0,           0,0,0,         0,0,0, 0,0,64'h0,       32'h20, 0));
    tbl.push_back(v(1,1,5,0,0,0, 1,5,64'hDEADBEEF,0,0,0,         0,1,0, 1,5,64'hDEADBEEF,32'h20, 0));
    tbl.push_back(v(1,1,5,0,0,0, 0,0,0,           0,0,0,         0,0,0, 0,5,64'hDEADBEEF,32'h0,  0));
    tbl.push_back(v(1,1,5,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,5,64'hDEADBEEF,32'h0,  0));
    // contention: first contested pair goes EXU-first
    tbl.push_back(v(1,1,0,0,3,1, 0,0,0,           0,0,0,         1,0,0, 0,5,64'hDEADBEEF,32'h8,  0));
    tbl.push_back(v(1,1,0,0,4,1, 0,0,0,           0,0,0,         1,0,0, 0,5,64'hDEADBEEF,32'h18, 0));
    tbl.push_back(v(1,0,0,0,0,0, 1,3,64'h33,      1,4,64'h44,    1,1,0, 1,3,64'h33,      32'h18, 0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           1,4,64'h44,    1,0,1, 1,4,64'h44,      32'h10, 0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,4,64'h44,      32'h0,  0));
    // second contested pair goes LSU-first (uncontested LSU grant did not flip)
    tbl.push_back(v(1,1,0,0,3,1, 0,0,0,           0,0,0,         1,0,0, 0,4,64'h44,      32'h8,  0));
    tbl.push_back(v(1,1,0,0,4,1, 0,0,0,           0,0,0,         1,0,0, 0,4,64'h44,      32'h18, 0));
    tbl.push_back(v(1,0,0,0,0,0, 1,3,64'h333,     1,4,64'h444,   1,0,1, 1,4,64'h444,     32'h18, 0));
    tbl.push_back(v(1,0,0,0,0,0, 1,3,64'h333,     0,0,0,         1,1,0, 1,3,64'h333,     32'h8,  0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,3,64'h333,     32'h0,  0));
    // x0: issue never sets busy, writeback consumes grant without wen
    tbl.push_back(v(1,1,0,0,0,1, 0,0,0,           0,0,0,         1,0,0, 0,3,64'h333,     32'h0,  0));
    tbl.push_back(v(1,0,0,0,0,0, 1,0,64'h55,      0,0,0,         1,1,0, 0,0,64'h55,      32'h0,  0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,0,64'h55,      32'h0,  0));
    // spurious LSU writeback to x9: performed, error sticky
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           1,9,64'h99,    1,0,1, 1,9,64'h99,      32'h0,  1));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,9,64'h99,      32'h0,  1));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,9,64'h99,      32'h0,  1));
    // set-wins: commit of x7 and new issue rd=7 on the same edge
    tbl.push_back(v(1,0,0,0,0,0, 1,7,64'h77,      0,0,0,         1,1,0, 1,7,64'h77,      32'h0,  1));
    tbl.push_back(v(1,1,0,0,7,1, 0,0,0,           0,0,0,         1,0,0, 0,7,64'h77,      32'h80, 1));
    tbl.push_back(v(1,0,0,0,0,0, 1,7,64'h777,     0,0,0,         1,1,0, 1,7,64'h777,     32'h80, 1));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,           0,0,0,         1,0,0, 0,7,64'h777,     32'h0,  1));

    @(posedge clk); #1;
    foreach (tbl[k]) apply(tbl[k], k);

    // reset mid-operation: in-flight write dropped, pointer back to EXU-first
    drive(v(1,1,0,0,12,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("mid_busy12", 100, 64'(busy), 64'h1000);
    drive(v(1,0,0,0,0,0, 1,12,64'hC, 1,13,64'hD, 0,0,0,0,0,0,0,0));
    #1;
    chk("mid_exu_first", 101, 64'(exu_ready), 64'h1);
    @(posedge clk); #1;
    chk("mid_wen", 102, 64'(gpr_wen), 64'h1);
    rst = 1'b0;
    #1;
    chk("rst_exu_ready", 103, 64'(exu_ready), 64'h0);
    chk("rst_lsu_ready", 103, 64'(lsu_ready), 64'h0);
    @(posedge clk); #1;
    chk("rst_wen",  104, 64'(gpr_wen),  64'h0);
    chk("rst_rw",   104, 64'(gpr_rw),   64'h0);
    chk("rst_busw", 104, gpr_busw,      64'h0);
    chk("rst_busy", 104, 64'(busy),     64'h0);
    chk("rst_err",  104, 64'(wb_err),   64'h0);
    rst = 1'b1;
    #1;
    chk("post_exu_ready", 105, 64'(exu_ready), 64'h1);
    chk("post_lsu_ready", 105, 64'(lsu_ready), 64'h0);
    @(posedge clk); #1;
    chk("post_rw",  106, 64'(gpr_rw), 64'd12);
    chk("post_err", 106, 64'(wb_err), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
